// File: rtl/udma_hyper_pkg.sv
// -----------------------------------------------------------------------------
// udma_hyper_pkg
//   Shared types and width defaults for the hyperbus command issue stage.
//   - hyper_cmd_t   : one transfer command (start address, byte count, dir).
//   - issue_state_e : launch FSM states of udma_hyper_cmd_issue.
// -----------------------------------------------------------------------------
package udma_hyper_pkg;

  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned SIZE_W_DEF = 16;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [SIZE_W_DEF-1:0] size;
    logic                  rw;    // 1 = read, 0 = write
  } hyper_cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_EOT = 2'd2
  } issue_state_e;

endpackage

// File: rtl/udma_hyper_cmd_fifo.sv
// -----------------------------------------------------------------------------
// udma_hyper_cmd_fifo
//   Synchronous FIFO of transfer commands with a flush input.
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     push_i, wdata_i    write request and command (ignored when full/clear)
//     pop_i,  rdata_o    read request and head command (rdata_o shows the head
//                        combinationally, valid whenever empty_o is low)
//     clear_i            drop every stored entry on the next edge; a
//                        simultaneous push is discarded, a simultaneous pop
//                        still sees the old head on rdata_o
//     full_o, empty_o    occupancy flags
//     level_o            number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module udma_hyper_cmd_fifo
  import udma_hyper_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter type         cmd_t = hyper_cmd_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  cmd_t             wdata_i,
  input  logic             pop_i,
  output cmd_t             rdata_o,
  input  logic             clear_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  cmd_t             mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers are PTR_W bits and DEPTH is a power of two, so the +1 wraps
  // modulo DEPTH by itself.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; an entry is
  // only ever read after it has been written, and unreset arrays map to RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/udma_hyper_cmd_issue.sv
// -----------------------------------------------------------------------------
// udma_hyper_cmd_issue
//   Sys-domain issue stage in front of the hyperbus busy/EOT tracker. Commands
//   pushed by the uDMA register file are queued and launched one at a time on
//   the PHY launch interface; the next launch waits for the tracker's EOT.
//   Ports:
//     sys_clk_i, rst_ni        clock, asynchronous active-low reset
//     cfg_valid_i/cfg_ready_o  command push handshake (ready = queue not full)
//     cfg_addr_i/size_i/rw_i   pushed command; size 0 is dropped and flagged
//     cfg_clear_i              flush queued, not yet launched commands
//     trans_valid_o/ready_i    launch handshake towards the PHY
//     trans_addr/size/rw_o     presented command, stable while valid
//     running_trans_sys_o      to tracker: work queued or presented (registered)
//     proc_id_sys_o            to tracker: launch hand-off in progress
//     evt_eot_i                from tracker: end-of-transfer pulse
//     level_o                  queued commands, excluding the presented one
//     err_size0_o              one-cycle pulse after a size-0 push was dropped
// -----------------------------------------------------------------------------
module udma_hyper_cmd_issue
  import udma_hyper_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned SIZE_W = SIZE_W_DEF
) (
  input  logic                       sys_clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [ADDR_W-1:0]          cfg_addr_i,
  input  logic [SIZE_W-1:0]          cfg_size_i,
  input  logic                       cfg_rw_i,
  input  logic                       cfg_clear_i,
  output logic                       trans_valid_o,
  input  logic                       trans_ready_i,
  output logic [ADDR_W-1:0]          trans_addr_o,
  output logic [SIZE_W-1:0]          trans_size_o,
  output logic                       trans_rw_o,
  output logic                       running_trans_sys_o,
  output logic                       proc_id_sys_o,
  input  logic                       evt_eot_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       err_size0_o
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  // hyper_cmd_t resized to this instance's address/size widths.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic              rw;
  } cmd_t;

  issue_state_e state_q, state_d;
  cmd_t         cmd_q, cmd_d;
  logic         running_q, running_d;
  logic         err_size0_q, err_size0_d;

  logic             push_req;
  logic             fifo_push;
  logic             fifo_pop;
  cmd_t             fifo_wdata;
  cmd_t             fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;

  // A size-0 command still completes the push handshake; it is just not stored.
  assign push_req   = cfg_valid_i & cfg_ready_o;
  assign fifo_push  = push_req & (cfg_size_i != '0);
  assign fifo_wdata = '{addr: cfg_addr_i, size: cfg_size_i, rw: cfg_rw_i};

  udma_hyper_cmd_fifo #(
    .DEPTH (DEPTH),
    .cmd_t (cmd_t)
  ) u_fifo (
    .clk_i   (sys_clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .clear_i (cfg_clear_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Launch FSM. A pop in IDLE copies the head into cmd_q, so the presented
  // command is owned by this stage and a flush cannot disturb it.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_rdata;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        // valid is high for the whole state, so ready alone completes it.
        if (trans_ready_i) state_d = WAIT_EOT;
      end
      WAIT_EOT: begin
        // EOT outside this state belongs to no launch of ours and is ignored.
        if (evt_eot_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tracker flag samples the current level/state, so it lags them by a cycle.
  always_comb begin
    running_d   = (fifo_level != '0) | (state_q == PRESENT);
    err_size0_d = push_req & (cfg_size_i == '0);
  end

  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      running_q   <= 1'b0;
      err_size0_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      running_q   <= running_d;
      err_size0_q <= err_size0_d;
    end
  end

  assign cfg_ready_o         = ~fifo_full;
  assign level_o             = fifo_level;
  assign trans_valid_o       = (state_q == PRESENT);
  assign proc_id_sys_o       = (state_q == PRESENT);
  assign trans_addr_o        = cmd_q.addr;
  assign trans_size_o        = cmd_q.size;
  assign trans_rw_o          = cmd_q.rw;
  assign running_trans_sys_o = running_q;
  assign err_size0_o         = err_size0_q;

endmodule

// File: tb/tb_udma_hyper_cmd_issue.sv
// -----------------------------------------------------------------------------
// tb_udma_hyper_cmd_issue
//   Directed scenarios followed by a randomized run. Every accepted command is
//   appended to exp_q; an independent monitor pops it on each launch handshake
//   and compares, and also checks that a presented command is held stable.
// -----------------------------------------------------------------------------
module tb_udma_hyper_cmd_issue;
  import udma_hyper_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int SIZE_W = 16;

  logic              sys_clk_i = 1'b0;
  logic              rst_ni;
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic [SIZE_W-1:0] cfg_size_i;
  logic              cfg_rw_i;
  logic              cfg_clear_i;
  logic              trans_valid_o;
  logic              trans_ready_i;
  logic [ADDR_W-1:0] trans_addr_o;
  logic [SIZE_W-1:0] trans_size_o;
  logic              trans_rw_o;
  logic              running_trans_sys_o;
  logic              proc_id_sys_o;
  logic              evt_eot_i;
  logic [2:0]        level_o;
  logic              err_size0_o;

  udma_hyper_cmd_issue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .SIZE_W (SIZE_W)
  ) dut (
    .sys_clk_i           (sys_clk_i),
    .rst_ni              (rst_ni),
    .cfg_valid_i         (cfg_valid_i),
    .cfg_ready_o         (cfg_ready_o),
    .cfg_addr_i          (cfg_addr_i),
    .cfg_size_i          (cfg_size_i),
    .cfg_rw_i            (cfg_rw_i),
    .cfg_clear_i         (cfg_clear_i),
    .trans_valid_o       (trans_valid_o),
    .trans_ready_i       (trans_ready_i),
    .trans_addr_o        (trans_addr_o),
    .trans_size_o        (trans_size_o),
    .trans_rw_o          (trans_rw_o),
    .running_trans_sys_o (running_trans_sys_o),
    .proc_id_sys_o       (proc_id_sys_o),
    .evt_eot_i           (evt_eot_i),
    .level_o             (level_o),
    .err_size0_o         (err_size0_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int         n_cmp = 0;
  int         n_mis = 0;
  hyper_cmd_t exp_q[$];
  int         exp_err  = 0;
  int         err_seen = 0;
  bit         push_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: got no such event, required it within the bound", name);
  endtask

  function automatic hyper_cmd_t mk(input logic [31:0] a, input logic [15:0] s, input logic rw);
    hyper_cmd_t c;
    c.addr = a;
    c.size = s;
    c.rw   = rw;
    return c;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are read on the
  // falling edge.
  task automatic cyc();
    @(posedge sys_clk_i);
    #1;
  endtask

  // Holds the push until accepted; the reference queue learns the command
  // when the push is certain to land on the coming edge.
  task automatic push(input logic [31:0] a, input logic [15:0] s, input logic rw);
    cfg_valid_i = 1'b1;
    cfg_addr_i  = a;
    cfg_size_i  = s;
    cfg_rw_i    = rw;
    for (int t = 0; ; t++) begin
      @(negedge sys_clk_i);
      if (cfg_ready_o) break;
      if (t == 300) begin
        fail("push_timeout");
        cfg_valid_i = 1'b0;
        return;
      end
      cyc();
    end
    if (s == '0) exp_err++;
    else         exp_q.push_back(mk(a, s, rw));
    cyc();
    cfg_valid_i = 1'b0;
  endtask

  // Returns on a falling edge where trans_valid_o is high.
  task automatic wait_valid(input string name);
    for (int t = 0; t < 50; t++) begin
      @(negedge sys_clk_i);
      if (trans_valid_o) return;
      cyc();
    end
    fail(name);
  endtask

  // Accept the presented command, answer with EOT, and check that the next
  // command (if any is queued) appears exactly two cycles after the pulse.
  task automatic launch_and_eot(input string tag);
    bit exp_next;
    trans_ready_i = 1'b1;
    wait_valid({tag, "_valid_timeout"});
    cyc();
    trans_ready_i = 1'b0;
    @(negedge sys_clk_i);
    check({tag, "_valid_in_wait_eot"}, trans_valid_o, 0);
    cyc();
    evt_eot_i = 1'b1;
    exp_next  = (exp_q.size() != 0);
    cyc();
    evt_eot_i = 1'b0;
    @(negedge sys_clk_i);
    check({tag, "_valid_eot_plus1"}, trans_valid_o, 0);
    cyc();
    @(negedge sys_clk_i);
    check({tag, "_valid_eot_plus2"}, trans_valid_o, exp_next);
    cyc();
  endtask

  // Scoreboard monitor.
  logic       prev_hold;
  hyper_cmd_t prev_cmd;
  hyper_cmd_t mon_exp;

  always @(negedge sys_clk_i) begin
    if (!rst_ni) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", trans_valid_o, 1);
        check("hold_data", mk(trans_addr_o, trans_size_o, trans_rw_o), prev_cmd);
      end
      if (err_size0_o) err_seen++;
      if (trans_valid_o && trans_ready_i) begin
        if (exp_q.size() == 0) begin
          fail("launch_without_queued_command");
        end else begin
          mon_exp = exp_q.pop_front();
          check("launch_data", mk(trans_addr_o, trans_size_o, trans_rw_o), mon_exp);
        end
      end
      prev_hold = trans_valid_o && !trans_ready_i;
      prev_cmd  = mk(trans_addr_o, trans_size_o, trans_rw_o);
    end
  end

  initial begin
    rst_ni        = 1'b0;
    cfg_valid_i   = 1'b0;
    cfg_addr_i    = '0;
    cfg_size_i    = '0;
    cfg_rw_i      = 1'b0;
    cfg_clear_i   = 1'b0;
    trans_ready_i = 1'b0;
    evt_eot_i     = 1'b0;
    push_done     = 1'b0;

    // Reset values.
    #12;
    check("rst_valid", trans_valid_o, 0);
    check("rst_ready", cfg_ready_o, 1);
    check("rst_level", level_o, 0);
    check("rst_running", running_trans_sys_o, 0);
    check("rst_proc_id", proc_id_sys_o, 0);
    check("rst_err", err_size0_o, 0);
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Single command: launch latency and tracker flags.
    trans_ready_i = 1'b1;
    cfg_valid_i   = 1'b1;
    cfg_addr_i    = 32'h1000;
    cfg_size_i    = 16'd64;
    cfg_rw_i      = 1'b1;
    exp_q.push_back(mk(32'h1000, 16'd64, 1'b1));
    @(negedge sys_clk_i);
    check("t1_cfg_ready", cfg_ready_o, 1);
    cyc();
    cfg_valid_i = 1'b0;
    @(negedge sys_clk_i);
    check("t1_level_after_push", level_o, 1);
    check("t1_valid_push_plus1", trans_valid_o, 0);
    check("t1_running_push_plus1", running_trans_sys_o, 0);
    cyc();
    @(negedge sys_clk_i);
    check("t1_valid_push_plus2", trans_valid_o, 1);
    check("t1_addr", trans_addr_o, 32'h1000);
    check("t1_size", trans_size_o, 16'd64);
    check("t1_proc_id_high", proc_id_sys_o, 1);
    check("t1_running_high", running_trans_sys_o, 1);
    check("t1_level_after_pop", level_o, 0);
    cyc();
    @(negedge sys_clk_i);
    check("t1_valid_after_hs", trans_valid_o, 0);
    check("t1_proc_id_after_hs", proc_id_sys_o, 0);
    check("t1_running_hs_plus1", running_trans_sys_o, 1);
    cyc();
    @(negedge sys_clk_i);
    check("t1_running_hs_plus2", running_trans_sys_o, 0);
    cyc();
    evt_eot_i = 1'b1;
    cyc();
    evt_eot_i     = 1'b0;
    trans_ready_i = 1'b0;
    cyc();

    // Fill the queue behind a stalled launch, then hold ready low.
    push(32'h2000, 16'd16, 1'b0);
    push(32'h2100, 16'd32, 1'b1);
    push(32'h2200, 16'd48, 1'b0);
    push(32'h2300, 16'd80, 1'b1);
    push(32'h2400, 16'd96, 1'b0);
    @(negedge sys_clk_i);
    check("t2_level_full", level_o, 4);
    check("t2_ready_full", cfg_ready_o, 0);
    check("t2_valid", trans_valid_o, 1);
    check("t2_head_addr", trans_addr_o, 32'h2000);
    for (int i = 0; i < 10; i++) begin
      cyc();
      evt_eot_i = (i == 4);
      @(negedge sys_clk_i);
      check("t3_valid_stall", trans_valid_o, 1);
      check("t3_addr_stall", trans_addr_o, 32'h2000);
      check("t3_proc_id_stall", proc_id_sys_o, 1);
    end
    cyc();
    evt_eot_i = 1'b0;
    for (int i = 0; i < 5; i++) launch_and_eot("t2_drain");

    // Flush while a launch waits for its EOT.
    push(32'h3000, 16'd8, 1'b1);
    push(32'h3100, 16'd8, 1'b0);
    push(32'h3200, 16'd8, 1'b1);
    trans_ready_i = 1'b1;
    wait_valid("t4_valid_timeout");
    cyc();
    trans_ready_i = 1'b0;
    @(negedge sys_clk_i);
    check("t4_level_before_clear", level_o, 2);
    cyc();
    cfg_clear_i = 1'b1;
    cyc();
    cfg_clear_i = 1'b0;
    exp_q.delete();
    @(negedge sys_clk_i);
    check("t4_level_cleared", level_o, 0);
    check("t4_ready_cleared", cfg_ready_o, 1);
    cyc();
    evt_eot_i = 1'b1;
    cyc();
    evt_eot_i = 1'b0;
    cyc();
    cyc();
    @(negedge sys_clk_i);
    check("t4_valid_after_eot", trans_valid_o, 0);
    check("t4_running_after_eot", running_trans_sys_o, 0);
    check("t4_proc_id_after_eot", proc_id_sys_o, 0);
    cyc();

    // Size-0 push is dropped and flagged once.
    push(32'h5000, 16'd0, 1'b0);
    @(negedge sys_clk_i);
    check("t5_err_pulse", err_size0_o, 1);
    check("t5_level", level_o, 0);
    cyc();
    @(negedge sys_clk_i);
    check("t5_err_single", err_size0_o, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge sys_clk_i);
      check("t5_no_launch", trans_valid_o, 0);
    end
    cyc();

    // Asynchronous reset while presenting.
    push(32'h6000, 16'd4, 1'b1);
    push(32'h6100, 16'd4, 1'b0);
    wait_valid("t6_valid_timeout");
    cyc();
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_valid_async", trans_valid_o, 0);
    check("t6_proc_id_async", proc_id_sys_o, 0);
    check("t6_running_async", running_trans_sys_o, 0);
    check("t6_level_async", level_o, 0);
    check("t6_ready_async", cfg_ready_o, 1);
    exp_q.delete();
    cyc();
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge sys_clk_i);
      check("t6_no_launch_after_reset", trans_valid_o, 0);
    end
    cyc();

    // Randomized traffic: random sizes (some 0), gaps, ready and EOT delay.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          push($urandom,
               ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)),
               1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 3)) cyc();
        end
        push_done = 1'b1;
      end
      begin
        logic hs;
        bit   pending;
        bit   finished;
        int   eot_wait;
        pending  = 1'b0;
        finished = 1'b0;
        eot_wait = 0;
        for (int n = 0; n < 5000; n++) begin
          @(negedge sys_clk_i);
          hs = trans_valid_o && trans_ready_i;
          cyc();
          evt_eot_i     = 1'b0;
          trans_ready_i = 1'($urandom_range(0, 1));
          if (pending) begin
            if (eot_wait == 0) begin
              evt_eot_i = 1'b1;
              pending   = 1'b0;
            end else begin
              eot_wait--;
            end
          end
          if (hs) begin
            pending  = 1'b1;
            eot_wait = $urandom_range(0, 3);
          end
          if (push_done && exp_q.size() == 0 && !pending && !hs && !evt_eot_i) begin
            finished = 1'b1;
            break;
          end
        end
        evt_eot_i     = 1'b0;
        trans_ready_i = 1'b0;
        if (!finished) fail("random_drain_timeout");
      end
    join

    cyc();
    @(negedge sys_clk_i);
    check("err_pulse_count", err_seen, exp_err);
    check("queue_drained", exp_q.size(), 0);
    check("final_level", level_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
